// File: rtl/id_issue_if.sv
// id_issue bus interface: front-end handshake, register-file read port,
// forwarding sources and the registered ID/EX outputs of the decode/issue stage.
interface id_issue_if #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 2
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_pc;
    logic [31:0]               in_inst;
    logic                      flush;
    logic                      rf_re1;
    logic                      rf_re2;
    logic [4:0]                rf_addr1;
    logic [4:0]                rf_addr2;
    logic [DATA_W-1:0]         rf_data1;
    logic [DATA_W-1:0]         rf_data2;
    logic [FWD_N-1:0]          fwd_we;
    logic [5*FWD_N-1:0]        fwd_wd;
    logic [DATA_W*FWD_N-1:0]   fwd_wdata;
    logic [FWD_N-1:0]          fwd_is_load;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_pc;
    logic [31:0]               out_inst;
    logic [DATA_W-1:0]         out_reg1;
    logic [DATA_W-1:0]         out_reg2;
    logic [4:0]                out_wd;
    logic                      out_wreg;
    logic [DATA_W-1:0]         out_link;
    logic                      out_in_delayslot;
    logic                      out_illegal;
    logic                      branch_flag;
    logic [DATA_W-1:0]         branch_target;
    logic [31:0]               stall_cycles;

    // The issue stage itself.
    modport slave (
        input  in_valid, in_pc, in_inst, flush, rf_data1, rf_data2,
               fwd_we, fwd_wd, fwd_wdata, fwd_is_load, out_ready,
        output in_ready, rf_re1, rf_re2, rf_addr1, rf_addr2,
               out_valid, out_pc, out_inst, out_reg1, out_reg2, out_wd, out_wreg,
               out_link, out_in_delayslot, out_illegal, branch_flag, branch_target,
               stall_cycles
    );

    // The surrounding pipeline driving the stage.
    modport master (
        output in_valid, in_pc, in_inst, flush, rf_data1, rf_data2,
               fwd_we, fwd_wd, fwd_wdata, fwd_is_load, out_ready,
        input  in_ready, rf_re1, rf_re2, rf_addr1, rf_addr2,
               out_valid, out_pc, out_inst, out_reg1, out_reg2, out_wd, out_wreg,
               out_link, out_in_delayslot, out_illegal, branch_flag, branch_target,
               stall_cycles
    );
endinterface

// File: rtl/id_issue.sv
// id_issue: MIPS decode/issue stage. Decodes register usage and immediates,
// selects operands (forwarding beats the register file, youngest source wins),
// stalls on load-use, resolves branches/jumps in the fire cycle and registers
// the result into the ID/EX holding register behind a valid/ready handshake.
module id_issue #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 2
) (
    input  logic        clk,
    input  logic        rst,
    id_issue_if.slave   bus
);
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08;
    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    // Returns {hit, is_load, data} of the youngest source writing register a.
    function automatic logic [DATA_W+1:0] fwd_pick(
        input logic [4:0]                a,
        input logic [FWD_N-1:0]          we,
        input logic [5*FWD_N-1:0]        wd,
        input logic [DATA_W*FWD_N-1:0]   wdata,
        input logic [FWD_N-1:0]          ld
    );
        logic              hit;
        logic              isld;
        logic              m;
        logic [DATA_W-1:0] val;
        hit  = 1'b0;
        isld = 1'b0;
        val  = '0;
        // Walk oldest to youngest so the youngest match is the one that sticks.
        for (int k = FWD_N - 1; k >= 0; k--) begin
            m    = we[k] && (wd[5*k +: 5] == a);
            hit  = hit | m;
            isld = m ? ld[k] : isld;
            val  = m ? wdata[DATA_W*k +: DATA_W] : val;
        end
        return {hit, isld, val};
    endfunction

    logic [5:0]        w_op, w_fn;
    logic [4:0]        w_rs, w_rt, w_rd, w_sa;
    logic [DATA_W-1:0] w_sext, w_zext, w_pc4, w_pc8, w_btgt, w_jtgt;
    logic              w_shift;
    logic              w_use1, w_use2, w_wreg, w_illegal, w_is_br;
    logic [4:0]        w_wd;
    logic [DATA_W-1:0] w_imm1, w_imm2, w_link;
    logic [DATA_W+1:0] w_p1, w_p2;
    logic              w_live1, w_live2, w_stall, w_in_ready, w_fire, w_taken;
    logic [DATA_W-1:0] w_reg1, w_reg2, w_target;

    logic              r_out_valid, r_dly_pend, r_out_wreg, r_out_ds, r_out_illegal;
    logic [DATA_W-1:0] r_out_pc, r_out_reg1, r_out_reg2, r_out_link;
    logic [31:0]       r_out_inst, r_stall_cycles;
    logic [4:0]        r_out_wd;

    assign w_op    = bus.in_inst[31:26];
    assign w_rs    = bus.in_inst[25:21];
    assign w_rt    = bus.in_inst[20:16];
    assign w_rd    = bus.in_inst[15:11];
    assign w_sa    = bus.in_inst[10:6];
    assign w_fn    = bus.in_inst[5:0];
    assign w_sext  = {{(DATA_W-16){bus.in_inst[15]}}, bus.in_inst[15:0]};
    assign w_zext  = {{(DATA_W-16){1'b0}}, bus.in_inst[15:0]};
    assign w_pc4   = bus.in_pc + DATA_W'(32'd4);
    assign w_pc8   = bus.in_pc + DATA_W'(32'd8);
    assign w_btgt  = w_pc4 + (w_sext << 2'd2);
    assign w_jtgt  = {w_pc4[DATA_W-1:28], bus.in_inst[25:0], 2'b00};
    assign w_shift = (bus.in_inst[31:21] == 11'd0) &&
                     ((w_fn == FN_SLL) || (w_fn == FN_SRL) || (w_fn == FN_SRA));

    // Decode: which sources are read, destination, immediates, link, class.
    always_comb begin
        w_use1    = 1'b0;
        w_use2    = 1'b0;
        w_wreg    = 1'b0;
        w_wd      = 5'd0;
        w_imm1    = '0;
        w_imm2    = '0;
        w_link    = '0;
        w_illegal = 1'b0;
        w_is_br   = 1'b0;
        case (w_op)
            OP_SPECIAL: begin
                if (w_shift) begin
                    w_use2 = 1'b1;
                    w_wreg = 1'b1;
                    w_wd   = w_rd;
                    w_imm1 = {{(DATA_W-5){1'b0}}, w_sa};
                end else if (w_fn == FN_JR) begin
                    w_use1  = 1'b1;
                    w_is_br = 1'b1;
                end else begin
                    w_use1 = 1'b1;
                    w_use2 = 1'b1;
                    w_wreg = 1'b1;
                    w_wd   = w_rd;
                end
            end
            OP_REGIMM: begin
                case (w_rt)
                    RT_BLTZ, RT_BGEZ: begin
                        w_use1  = 1'b1;
                        w_is_br = 1'b1;
                    end
                    RT_BLTZAL, RT_BGEZAL: begin
                        w_use1  = 1'b1;
                        w_is_br = 1'b1;
                        w_wreg  = 1'b1;
                        w_wd    = 5'd31;
                        w_link  = w_pc8;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_J:   w_is_br = 1'b1;
            OP_JAL: begin
                w_is_br = 1'b1;
                w_wreg  = 1'b1;
                w_wd    = 5'd31;
                w_link  = w_pc8;
            end
            OP_BEQ, OP_BNE: begin
                w_use1  = 1'b1;
                w_use2  = 1'b1;
                w_is_br = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                w_use1  = 1'b1;
                w_is_br = 1'b1;
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                w_use1 = 1'b1;
                w_wreg = 1'b1;
                w_wd   = w_rt;
                w_imm2 = w_zext;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                w_use1 = 1'b1;
                w_wreg = 1'b1;
                w_wd   = w_rt;
                w_imm2 = w_sext;
            end
            OP_LUI: begin
                w_wreg = 1'b1;
                w_wd   = w_rt;
                w_imm2 = w_zext << 5'd16;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_p1    = fwd_pick(w_rs, bus.fwd_we, bus.fwd_wd, bus.fwd_wdata, bus.fwd_is_load);
    assign w_p2    = fwd_pick(w_rt, bus.fwd_we, bus.fwd_wd, bus.fwd_wdata, bus.fwd_is_load);
    assign w_live1 = w_use1 && (w_rs != 5'd0);
    assign w_live2 = w_use2 && (w_rt != 5'd0);
    assign w_stall = (w_live1 && w_p1[DATA_W+1] && w_p1[DATA_W]) ||
                     (w_live2 && w_p2[DATA_W+1] && w_p2[DATA_W]);

    // Operand select: a live source takes forwarding if matched, else the RF.
    always_comb begin
        w_reg1 = w_imm1;
        w_reg2 = w_imm2;
        if (w_live1) begin
            w_reg1 = w_p1[DATA_W+1] ? w_p1[DATA_W-1:0] : bus.rf_data1;
        end else begin
            w_reg1 = w_imm1;
        end
        if (w_live2) begin
            w_reg2 = w_p2[DATA_W+1] ? w_p2[DATA_W-1:0] : bus.rf_data2;
        end else begin
            w_reg2 = w_imm2;
        end
    end

    assign w_in_ready = !bus.flush && !w_stall && (!r_out_valid || bus.out_ready);
    assign w_fire     = bus.in_valid && w_in_ready;

    // Branch resolution on the selected operands.
    always_comb begin
        w_taken  = 1'b0;
        w_target = w_btgt;
        case (w_op)
            OP_SPECIAL: begin
                if (w_is_br) begin
                    w_taken  = 1'b1;
                    w_target = w_reg1;
                end else begin
                    w_taken  = 1'b0;
                end
            end
            OP_REGIMM: begin
                case (w_rt)
                    RT_BGEZ, RT_BGEZAL: w_taken = !w_reg1[DATA_W-1];
                    RT_BLTZ, RT_BLTZAL: w_taken = w_reg1[DATA_W-1];
                    default:            w_taken = 1'b0;
                endcase
            end
            OP_J, OP_JAL: begin
                w_taken  = 1'b1;
                w_target = w_jtgt;
            end
            OP_BEQ:  w_taken = (w_reg1 == w_reg2);
            OP_BNE:  w_taken = (w_reg1 != w_reg2);
            OP_BLEZ: w_taken = w_reg1[DATA_W-1] || (w_reg1 == '0);
            OP_BGTZ: w_taken = !w_reg1[DATA_W-1] && (w_reg1 != '0);
            default: w_taken = 1'b0;
        endcase
    end

    // ID/EX holding register and delay-slot tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_dly_pend    <= 1'b0;
            r_out_pc      <= '0;
            r_out_inst    <= 32'd0;
            r_out_reg1    <= '0;
            r_out_reg2    <= '0;
            r_out_wd      <= 5'd0;
            r_out_wreg    <= 1'b0;
            r_out_link    <= '0;
            r_out_ds      <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_dly_pend  <= 1'b0;
        end else if (w_fire) begin
            r_out_valid   <= 1'b1;
            r_dly_pend    <= w_is_br;
            r_out_pc      <= bus.in_pc;
            r_out_inst    <= bus.in_inst;
            r_out_reg1    <= w_reg1;
            r_out_reg2    <= w_reg2;
            r_out_wd      <= w_wd;
            r_out_wreg    <= w_wreg;
            r_out_link    <= w_link;
            r_out_ds      <= r_dly_pend;
            r_out_illegal <= w_illegal;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles a valid instruction is held by load-use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
        end else if (bus.in_valid && w_stall && !bus.flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.in_ready         = w_in_ready;
    assign bus.rf_re1           = w_use1;
    assign bus.rf_re2           = w_use2;
    assign bus.rf_addr1         = w_use1 ? w_rs : 5'd0;
    assign bus.rf_addr2         = w_use2 ? w_rt : 5'd0;
    assign bus.branch_flag      = w_fire && w_taken;
    assign bus.branch_target    = w_target;
    assign bus.out_valid        = r_out_valid;
    assign bus.out_pc           = r_out_pc;
    assign bus.out_inst         = r_out_inst;
    assign bus.out_reg1         = r_out_reg1;
    assign bus.out_reg2         = r_out_reg2;
    assign bus.out_wd           = r_out_wd;
    assign bus.out_wreg         = r_out_wreg;
    assign bus.out_link         = r_out_link;
    assign bus.out_in_delayslot = r_out_ds;
    assign bus.out_illegal      = r_out_illegal;
    assign bus.stall_cycles     = r_stall_cycles;
endmodule

// File: tb/tb_id_issue.sv
// Testbench for id_issue: directed scenarios plus randomized traffic checked
// against an instruction-level reference model.
module tb_id_issue;
    localparam int DW = 32;
    localparam int FN = 2;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] link;
        logic        ill;
        logic        br;
        logic        taken;
        logic [31:0] tgt;
        logic        stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic        t_we [FN];
    logic [4:0]  t_wd [FN];
    logic [31:0] t_wdata [FN];
    logic        t_ld [FN];
    logic [31:0] t_rf1, t_rf2;

    logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] fns [6]  = '{6'h21, 6'h25, 6'h08, 6'h00, 6'h02, 6'h03};
    logic [4:0] rts [5]  = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h05};

    id_issue_if #(.DATA_W(DW), .FWD_N(FN)) bus ();

    id_issue #(.DATA_W(DW), .FWD_N(FN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Value of register a as the stage must see it, with its load-in-flight flag.
    function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] rf, output logic ld);
        ld = 1'b0;
        if (a == 5'd0) return 32'd0;
        for (int k = 0; k < FN; k++) begin
            if (t_we[k] && t_wd[k] == a) begin
                ld = t_ld[k];
                return t_wdata[k];
            end
        end
        return rf;
    endfunction

    function automatic exp_t ref_model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t        e;
        logic        l1, l2;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] sx, pc4, bt;
        e = '0; l1 = 1'b0; l2 = 1'b0;
        op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11]; fn = inst[5:0];
        sx  = {{16{inst[15]}}, inst[15:0]};
        pc4 = pc + 32'd4;
        bt  = pc4 + sx * 32'd4;
        case (op)
            6'h00: begin
                if (inst[31:21] == 11'd0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
                    e.r1 = {27'd0, inst[10:6]}; e.r2 = src_val(rt, t_rf2, l2); e.wreg = 1'b1; e.wd = rd;
                end else if (fn == 6'h08) begin
                    e.r1 = src_val(rs, t_rf1, l1); e.br = 1'b1; e.taken = 1'b1; e.tgt = e.r1;
                end else begin
                    e.r1 = src_val(rs, t_rf1, l1); e.r2 = src_val(rt, t_rf2, l2); e.wreg = 1'b1; e.wd = rd;
                end
            end
            6'h01: begin
                if (rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11) begin
                    e.r1 = src_val(rs, t_rf1, l1); e.br = 1'b1; e.tgt = bt;
                    e.taken = rt[0] ? ($signed(e.r1) >= 0) : ($signed(e.r1) < 0);
                    if (rt[4]) begin e.wreg = 1'b1; e.wd = 5'd31; e.link = pc + 32'd8; end
                end else begin
                    e.ill = 1'b1;
                end
            end
            6'h02, 6'h03: begin
                e.br = 1'b1; e.taken = 1'b1; e.tgt = {pc4[31:28], inst[25:0], 2'b00};
                if (op == 6'h03) begin e.wreg = 1'b1; e.wd = 5'd31; e.link = pc + 32'd8; end
            end
            6'h04, 6'h05: begin
                e.r1 = src_val(rs, t_rf1, l1); e.r2 = src_val(rt, t_rf2, l2); e.br = 1'b1; e.tgt = bt;
                e.taken = (op == 6'h04) ? (e.r1 == e.r2) : (e.r1 != e.r2);
            end
            6'h06, 6'h07: begin
                e.r1 = src_val(rs, t_rf1, l1); e.br = 1'b1; e.tgt = bt;
                e.taken = (op == 6'h06) ? ($signed(e.r1) <= 0) : ($signed(e.r1) > 0);
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                e.r1 = src_val(rs, t_rf1, l1); e.r2 = sx; e.wreg = 1'b1; e.wd = rt;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                e.r1 = src_val(rs, t_rf1, l1); e.r2 = {16'd0, inst[15:0]}; e.wreg = 1'b1; e.wd = rt;
            end
            6'h0F: begin
                e.r2 = {inst[15:0], 16'd0}; e.wreg = 1'b1; e.wd = rt;
            end
            default: e.ill = 1'b1;
        endcase
        e.stall = l1 | l2;
        return e;
    endfunction

    task automatic clr_fwd();
        for (int k = 0; k < FN; k++) begin
            t_we[k] = 1'b0; t_wd[k] = 5'd0; t_wdata[k] = 32'd0; t_ld[k] = 1'b0;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic fl, input logic rdy);
        bus.in_valid = v; bus.in_pc = pc; bus.in_inst = inst; bus.flush = fl; bus.out_ready = rdy;
        bus.rf_data1 = t_rf1; bus.rf_data2 = t_rf2;
        for (int k = 0; k < FN; k++) begin
            bus.fwd_we[k] = t_we[k];
            bus.fwd_wd[5*k +: 5] = t_wd[k];
            bus.fwd_wdata[32*k +: 32] = t_wdata[k];
            bus.fwd_is_load[k] = t_ld[k];
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_fwd(); t_rf1 = 32'd0; t_rf2 = 32'd0;
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clr_fwd(); t_rf1 = 32'd0; t_rf2 = 32'd0;
        rst = 1'b1;
        drive(1'b1, 32'h40, i_type(6'h0D, 5'd0, 5'd1, 16'h1234), 1'b0, 1'b1);
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %h expected 0", bus.stall_cycles); end
        checks++; if ({bus.out_pc, bus.out_wd, bus.out_wreg, bus.out_in_delayslot} !== 39'd0) begin
            errors++; $display("FAIL reset_regs: got pc=%h wd=%0d wreg=%b ds=%b expected all 0", bus.out_pc, bus.out_wd, bus.out_wreg, bus.out_in_delayslot); end
        rst = 1'b0;
    endtask

    task automatic test_fwd_imm();
        drive(1'b1, 32'h0, i_type(6'h0D, 5'd0, 5'd1, 16'h8000), 1'b0, 1'b1);
        tick();
        checks++; if ({bus.out_reg1, bus.out_reg2, bus.out_wd, bus.out_wreg} !== {32'd0, 32'h8000, 5'd1, 1'b1}) begin
            errors++; $display("FAIL ori: got r1=%h r2=%h wd=%0d wreg=%b expected 0 8000 1 1", bus.out_reg1, bus.out_reg2, bus.out_wd, bus.out_wreg); end
        t_we[0] = 1'b1; t_wd[0] = 5'd1; t_wdata[0] = 32'h8000; t_rf1 = 32'hDEAD;
        drive(1'b1, 32'h4, i_type(6'h08, 5'd1, 5'd2, 16'hFFFF), 1'b0, 1'b1);
        tick();
        checks++; if ({bus.out_reg1, bus.out_reg2, bus.out_wd, bus.out_wreg} !== {32'h8000, 32'hFFFF_FFFF, 5'd2, 1'b1}) begin
            errors++; $display("FAIL addi_fwd: got r1=%h r2=%h wd=%0d wreg=%b expected 8000 ffffffff 2 1", bus.out_reg1, bus.out_reg2, bus.out_wd, bus.out_wreg); end
    endtask

    task automatic test_load_use();
        do_reset();
        t_we[0] = 1'b1; t_wd[0] = 5'd3; t_wdata[0] = 32'hBAD0; t_ld[0] = 1'b1;
        drive(1'b1, 32'h10, r_type(5'd3, 5'd3, 5'd4, 6'h21), 1'b0, 1'b1);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready: got %b expected 0", bus.in_ready); end
        tick();
        checks++; if (bus.stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", bus.stall_cycles); end
        clr_fwd(); t_we[1] = 1'b1; t_wd[1] = 5'd3; t_wdata[1] = 32'h1234;
        drive(1'b1, 32'h10, r_type(5'd3, 5'd3, 5'd4, 6'h21), 1'b0, 1'b1);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %b expected 1", bus.in_ready); end
        tick();
        checks++; if ({bus.out_valid, bus.out_reg1, bus.out_reg2, bus.out_wd, bus.stall_cycles} !== {1'b1, 32'h1234, 32'h1234, 5'd4, 32'd1}) begin
            errors++; $display("FAIL lu_issue: got v=%b r1=%h r2=%h wd=%0d cnt=%0d expected 1 1234 1234 4 1", bus.out_valid, bus.out_reg1, bus.out_reg2, bus.out_wd, bus.stall_cycles); end
    endtask

    task automatic test_fwd_priority();
        clr_fwd(); t_rf1 = 32'h77; t_rf2 = 32'h55;
        t_we[0] = 1'b1; t_wd[0] = 5'd5; t_wdata[0] = 32'h11;
        t_we[1] = 1'b1; t_wd[1] = 5'd5; t_wdata[1] = 32'h22; t_ld[1] = 1'b1;
        drive(1'b1, 32'h20, r_type(5'd5, 5'd0, 5'd6, 6'h25), 1'b0, 1'b1);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL older_load_ignored: got %b expected 1", bus.in_ready); end
        tick();
        checks++; if ({bus.out_reg1, bus.out_reg2} !== {32'h11, 32'h0}) begin
            errors++; $display("FAIL youngest_wins: got r1=%h r2=%h expected 11 0", bus.out_reg1, bus.out_reg2); end
        t_wd[0] = 5'd0; t_wdata[0] = 32'hFFFF; t_ld[1] = 1'b0;
        drive(1'b1, 32'h24, r_type(5'd0, 5'd5, 5'd6, 6'h25), 1'b0, 1'b1);
        tick();
        checks++; if ({bus.out_reg1, bus.out_reg2} !== {32'h0, 32'h22}) begin
            errors++; $display("FAIL r0_zero: got r1=%h r2=%h expected 0 22", bus.out_reg1, bus.out_reg2); end
    endtask

    task automatic test_beq_delay_slot();
        clr_fwd(); t_rf1 = 32'd5; t_rf2 = 32'd5;
        drive(1'b1, 32'h100, i_type(6'h04, 5'd1, 5'd2, 16'h0004), 1'b0, 1'b1);
        checks++; if ({bus.branch_flag, bus.branch_target} !== {1'b1, 32'h114}) begin
            errors++; $display("FAIL beq_taken: got flag=%b tgt=%h expected 1 114", bus.branch_flag, bus.branch_target); end
        tick();
        checks++; if (bus.out_in_delayslot !== 1'b0) begin errors++; $display("FAIL beq_not_ds: got %b expected 0", bus.out_in_delayslot); end
        drive(1'b1, 32'h104, r_type(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 1'b1);
        tick();
        checks++; if (bus.out_in_delayslot !== 1'b1) begin errors++; $display("FAIL ds_tag: got %b expected 1", bus.out_in_delayslot); end
        drive(1'b1, 32'h108, r_type(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 1'b1);
        tick();
        checks++; if (bus.out_in_delayslot !== 1'b0) begin errors++; $display("FAIL ds_clear: got %b expected 0", bus.out_in_delayslot); end
    endtask

    task automatic test_bltzal();
        clr_fwd(); t_rf1 = 32'd1; t_rf2 = 32'd0;
        drive(1'b1, 32'h200, i_type(6'h01, 5'd1, 5'h10, 16'h0010), 1'b0, 1'b1);
        checks++; if (bus.branch_flag !== 1'b0) begin errors++; $display("FAIL bltzal_flag: got %b expected 0", bus.branch_flag); end
        tick();
        checks++; if ({bus.out_wd, bus.out_link, bus.out_wreg} !== {5'd31, 32'h208, 1'b1}) begin
            errors++; $display("FAIL bltzal_link: got wd=%0d link=%h wreg=%b expected 31 208 1", bus.out_wd, bus.out_link, bus.out_wreg); end
        drive(1'b1, 32'h204, r_type(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 1'b1);
        tick();
        checks++; if (bus.out_in_delayslot !== 1'b1) begin errors++; $display("FAIL bltzal_ds: got %b expected 1", bus.out_in_delayslot); end
    endtask

    task automatic test_backpressure_flush();
        clr_fwd(); t_rf1 = 32'd9; t_rf2 = 32'd9;
        drive(1'b1, 32'h300, i_type(6'h0D, 5'd0, 5'd7, 16'h0001), 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h304, i_type(6'h04, 5'd1, 5'd2, 16'h0008), 1'b0, 1'b0);
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            tick();
            checks++; if ({bus.out_valid, bus.out_pc, bus.out_reg2} !== {1'b1, 32'h300, 32'h1}) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h r2=%h expected 1 300 1", i, bus.out_valid, bus.out_pc, bus.out_reg2); end
        end
        drive(1'b1, 32'h304, i_type(6'h04, 5'd1, 5'd2, 16'h0008), 1'b1, 1'b0);
        checks++; if ({bus.in_ready, bus.branch_flag} !== 2'b00) begin
            errors++; $display("FAIL flush_comb: got ready=%b flag=%b expected 0 0", bus.in_ready, bus.branch_flag); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
        // Leave a jump's delay slot pending and a load-use stall active, then reset.
        drive(1'b1, 32'h400, {6'h02, 26'h40}, 1'b0, 1'b1);
        tick();
        t_we[0] = 1'b1; t_wd[0] = 5'd1; t_ld[0] = 1'b1;
        drive(1'b1, 32'h404, r_type(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.stall_cycles, bus.out_valid} !== 33'd0) begin
            errors++; $display("FAIL rst_mid_stall: got cnt=%0d v=%b expected 0 0", bus.stall_cycles, bus.out_valid); end
        clr_fwd();
        drive(1'b1, 32'h404, r_type(5'd1, 5'd2, 5'd3, 6'h21), 1'b0, 1'b1);
        tick();
        checks++; if ({bus.out_valid, bus.out_in_delayslot} !== 2'b10) begin
            errors++; $display("FAIL rst_ds_cleared: got v=%b ds=%b expected 1 0", bus.out_valid, bus.out_in_delayslot); end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 2));
            1:       return 32'h8000_0000 | 32'($urandom_range(0, 2));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        op = ops[$urandom_range(0, 19)];
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        if (op == 6'h00) begin
            fn = fns[$urandom_range(0, 5)];
            if (fn != 6'h21 && fn != 6'h25 && fn != 6'h08 && $urandom_range(0, 1) == 1) rs = 5'd0;
            return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
        end else if (op == 6'h01) begin
            return {op, rs, rts[$urandom_range(0, 4)], 16'($urandom)};
        end else if (op == 6'h02 || op == 6'h03) begin
            return {op, 26'($urandom)};
        end else begin
            return {op, rs, rt, 16'($urandom)};
        end
    endfunction

    task automatic test_random();
        exp_t        e, h_e;
        logic        ev, edly, h_ds, v, fl, rdy, fire, exp_rdy;
        logic [31:0] ecnt, pc, inst, h_pc, h_inst;
        do_reset();
        ev = 1'b0; edly = 1'b0; ecnt = 32'd0;
        h_e = '0; h_ds = 1'b0; h_pc = 32'd0; h_inst = 32'd0;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < FN; k++) begin
                t_we[k] = ($urandom_range(0, 2) != 0);
                t_wd[k] = 5'($urandom_range(0, 7));
                t_wdata[k] = rand_val();
                t_ld[k] = ($urandom_range(0, 4) == 0);
            end
            t_rf1 = rand_val(); t_rf2 = rand_val();
            inst = gen_inst();
            pc   = $urandom & 32'hFFFF_FFFC;
            v    = ($urandom_range(0, 7) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            drive(v, pc, inst, fl, rdy);
            e = ref_model(inst, pc);
            exp_rdy = !fl && !e.stall && (!ev || rdy);
            fire = v && exp_rdy;
            checks++; if (bus.in_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b inst=%h", i, bus.in_ready, exp_rdy, inst); end
            checks++; if (bus.branch_flag !== (fire && e.taken)) begin
                errors++; $display("FAIL rnd_bflag[%0d]: got %b expected %b inst=%h", i, bus.branch_flag, fire && e.taken, inst); end
            if (fire && e.taken) begin
                checks++; if (bus.branch_target !== e.tgt) begin
                    errors++; $display("FAIL rnd_btgt[%0d]: got %h expected %h inst=%h", i, bus.branch_target, e.tgt, inst); end
            end
            tick();
            if (v && e.stall && !fl && ecnt != 32'hFFFF_FFFF) ecnt = ecnt + 32'd1;
            if (fl) begin
                ev = 1'b0; edly = 1'b0;
            end else if (fire) begin
                ev = 1'b1; h_pc = pc; h_inst = inst; h_e = e; h_ds = edly; edly = e.br;
            end else if (rdy) begin
                ev = 1'b0;
            end
            checks++; if ({bus.out_valid, bus.stall_cycles} !== {ev, ecnt}) begin
                errors++; $display("FAIL rnd_state[%0d]: got v=%b cnt=%0d expected %b %0d", i, bus.out_valid, bus.stall_cycles, ev, ecnt); end
            if (ev) begin
                checks++;
                if ({bus.out_pc, bus.out_inst, bus.out_reg1, bus.out_reg2, bus.out_wd, bus.out_wreg, bus.out_link, bus.out_in_delayslot, bus.out_illegal}
                    !== {h_pc, h_inst, h_e.r1, h_e.r2, h_e.wd, h_e.wreg, h_e.link, h_ds, h_e.ill}) begin
                    errors++;
                    $display("FAIL rnd_idex[%0d]: got pc=%h inst=%h r1=%h r2=%h wd=%0d wreg=%b link=%h ds=%b ill=%b expected %h %h %h %h %0d %b %h %b %b",
                             i, bus.out_pc, bus.out_inst, bus.out_reg1, bus.out_reg2, bus.out_wd, bus.out_wreg, bus.out_link,
                             bus.out_in_delayslot, bus.out_illegal, h_pc, h_inst, h_e.r1, h_e.r2, h_e.wd, h_e.wreg, h_e.link, h_ds, h_e.ill);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_imm();
        test_load_use();
        test_fwd_priority();
        test_beq_delay_slot();
        test_bltzal();
        test_backpressure_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
